// File: rtl/wb_arbiter_pkg.sv
// Shared constants and types for the writeback arbiter slice.
// Replaces the old defines: XLEN, register address width, FIFO entry layout.
package wb_arbiter_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int WB_ENT_W   = REG_ADDR_W + XLEN;

   typedef enum logic [1:0] {
      GNT_IDLE,
      GNT_MEM,
      GNT_MDU
   } grant_e;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_ent_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO holding queued MDU results awaiting the regfile port.
// Ports: clk/rst (sync, active-high), push_i/data_i, pop_i/data_o, full_o, empty_o, count_o.
module wb_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           data_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             push_ok, pop_ok;

   // Extra pointer MSB separates full (MSBs differ) from empty.
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign count_o = wr_ptr_q - rd_ptr_q;
   assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
   end

endmodule

// File: rtl/wb_arbiter.sv
// Merges in-order MEM results and queued out-of-order MDU results onto one regfile write port.
// Ports: mem_* request, mdu_* valid/ready result, pipe_stall_o, registered wb_* write bus, buf_count_o.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int BUF_DEPTH  = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [REG_ADDR_W-1:0]       mem_rdaddr_i,
   input  logic [XLEN-1:0]             mem_rddata_i,
   input  logic                        mem_rdwe,
   input  logic                        mdu_valid_i,
   input  logic [REG_ADDR_W-1:0]       mdu_rdaddr_i,
   input  logic [XLEN-1:0]             mdu_rddata_i,
   output logic                        mdu_ready_o,
   output logic                        pipe_stall_o,
   output logic [REG_ADDR_W-1:0]       wb_rdaddr_o,
   output logic [XLEN-1:0]             wb_rddata_o,
   output logic                        wb_rdwe,
   output logic [$clog2(BUF_DEPTH):0]  buf_count_o
);

   localparam int SW = $clog2(STARVE_MAX + 1);

   grant_e                gnt;
   wb_ent_t               mdu_ent, head;
   logic                  mem_req, fifo_full, fifo_empty, fifo_ne;
   logic                  mdu_acc, push, pop, starved;
   logic [SW-1:0]         starve_q, starve_d;
   logic [REG_ADDR_W-1:0] wb_rdaddr_q, wb_rdaddr_d;
   logic [XLEN-1:0]       wb_rddata_q, wb_rddata_d;
   logic                  wb_rdwe_q, wb_rdwe_d;

   // Writes to x0 are architecturally void, so they never compete.
   assign mem_req = mem_rdwe & (mem_rdaddr_i != '0);
   assign fifo_ne = ~fifo_empty;
   assign starved = (starve_q == SW'(STARVE_MAX));

   assign mdu_ready_o = ~fifo_full & ~rst;
   assign mdu_acc     = mdu_valid_i & mdu_ready_o;
   assign push        = mdu_acc & (mdu_rdaddr_i != '0);
   assign mdu_ent     = '{rd: mdu_rdaddr_i, data: mdu_rddata_i};

   wb_fifo #(
      .WIDTH (WB_ENT_W),
      .DEPTH (BUF_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .data_i  (mdu_ent),
      .pop_i   (pop),
      .data_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (buf_count_o)
   );

   // MEM normally wins; the queue takes over when idle, starved or full.
   always_comb begin
      gnt = GNT_IDLE;
      if (fifo_ne && (!mem_req || starved || fifo_full)) begin
         gnt = GNT_MDU;
      end else if (mem_req) begin
         gnt = GNT_MEM;
      end
   end

   assign pop          = (gnt == GNT_MDU);
   assign pipe_stall_o = mem_req & (gnt == GNT_MDU) & ~rst;

   always_comb begin
      starve_d = starve_q;
      if (gnt == GNT_MDU || !fifo_ne) begin
         starve_d = '0;
      end else if (gnt == GNT_MEM && !starved) begin
         starve_d = starve_q + 1'b1;
      end
   end

   // Idle keeps addr/data so forwarding sees a stable bus.
   always_comb begin
      wb_rdwe_d   = 1'b0;
      wb_rdaddr_d = wb_rdaddr_q;
      wb_rddata_d = wb_rddata_q;
      unique case (gnt)
         GNT_MDU: begin
            wb_rdwe_d   = 1'b1;
            wb_rdaddr_d = head.rd;
            wb_rddata_d = head.data;
         end
         GNT_MEM: begin
            wb_rdwe_d   = 1'b1;
            wb_rdaddr_d = mem_rdaddr_i;
            wb_rddata_d = mem_rddata_i;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_q    <= '0;
         wb_rdwe_q   <= 1'b0;
         wb_rdaddr_q <= '0;
         wb_rddata_q <= '0;
      end else begin
         starve_q    <= starve_d;
         wb_rdwe_q   <= wb_rdwe_d;
         wb_rdaddr_q <= wb_rdaddr_d;
         wb_rddata_q <= wb_rddata_d;
      end
   end

   assign wb_rdwe     = wb_rdwe_q;
   assign wb_rdaddr_o = wb_rdaddr_q;
   assign wb_rddata_o = wb_rddata_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected writes queued on drive, popped by a write monitor.
// Ports: none; drives all wb_arbiter inputs and checks outputs plus write order.
module tb_wb_arbiter;
   import wb_arbiter_pkg::*;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  mem_rdaddr_i;
   logic [31:0] mem_rddata_i;
   logic        mem_rdwe;
   logic        mdu_valid_i;
   logic [4:0]  mdu_rdaddr_i;
   logic [31:0] mdu_rddata_i;
   logic        mdu_ready_o;
   logic        pipe_stall_o;
   logic [4:0]  wb_rdaddr_o;
   logic [31:0] wb_rddata_o;
   logic        wb_rdwe;
   logic [1:0]  buf_count_o;

   int   checks = 0;
   int   passes = 0;
   exp_t sb[$];

   wb_arbiter #(.BUF_DEPTH(2), .STARVE_MAX(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .mem_rdaddr_i (mem_rdaddr_i),
      .mem_rddata_i (mem_rddata_i),
      .mem_rdwe     (mem_rdwe),
      .mdu_valid_i  (mdu_valid_i),
      .mdu_rdaddr_i (mdu_rdaddr_i),
      .mdu_rddata_i (mdu_rddata_i),
      .mdu_ready_o  (mdu_ready_o),
      .pipe_stall_o (pipe_stall_o),
      .wb_rdaddr_o  (wb_rdaddr_o),
      .wb_rddata_o  (wb_rddata_o),
      .wb_rdwe      (wb_rdwe),
      .buf_count_o  (buf_count_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      mem_rdwe     = 1'b0;
      mem_rdaddr_i = '0;
      mem_rddata_i = '0;
      mdu_valid_i  = 1'b0;
      mdu_rdaddr_i = '0;
      mdu_rddata_i = '0;
   endtask

   task automatic mem_drv(input logic [4:0] rd, input logic [31:0] d);
      mem_rdwe     = 1'b1;
      mem_rdaddr_i = rd;
      mem_rddata_i = d;
   endtask

   task automatic mdu_drv(input logic [4:0] rd, input logic [31:0] d);
      mdu_valid_i  = 1'b1;
      mdu_rdaddr_i = rd;
      mdu_rddata_i = d;
   endtask

   task automatic push_exp(input logic [4:0] rd, input logic [31:0] d);
      exp_t e;
      e.rd   = rd;
      e.data = d;
      sb.push_back(e);
   endtask

   task automatic drain(input string tag, input int n);
      repeat (n) cyc();
      chk(tag, 64'(sb.size()), 64'd0);
   endtask

   // Every visible write must be the oldest outstanding expectation.
   always @(negedge clk) begin : mon
      exp_t e;
      if (wb_rdwe === 1'b1) begin
         if (sb.size() == 0) begin
            chk("spurious_wr", 64'(wb_rdwe), 64'd0);
         end else begin
            e = sb.pop_front();
            chk("wr_rd", 64'(wb_rdaddr_o), 64'(e.rd));
            chk("wr_data", 64'(wb_rddata_o), 64'(e.data));
         end
      end
   end

   initial begin
      rst = 1'b1;
      idle();
      cyc();
      cyc();
      mem_drv(5'd5, 32'h11);
      mdu_drv(5'd7, 32'h77);
      #1;
      chk("rst_we", 64'(wb_rdwe), 64'd0);
      chk("rst_addr", 64'(wb_rdaddr_o), 64'd0);
      chk("rst_data", 64'(wb_rddata_o), 64'd0);
      chk("rst_count", 64'(buf_count_o), 64'd0);
      chk("rst_ready", 64'(mdu_ready_o), 64'd0);
      chk("rst_stall", 64'(pipe_stall_o), 64'd0);
      cyc();
      chk("rst_noacc", 64'(buf_count_o), 64'd0);
      rst = 1'b0;
      idle();
      cyc();

      // MEM only
      for (int i = 0; i < 4; i++) begin
         mem_drv(5'd5, 32'h11 + 32'(i));
         push_exp(5'd5, 32'h11 + 32'(i));
         #1;
         chk("t1_stall", 64'(pipe_stall_o), 64'd0);
         cyc();
         chk("t1_we", 64'(wb_rdwe), 64'd1);
      end
      idle();
      drain("t1_drain", 2);

      // MDU only, two-cycle latency then hold on idle
      mdu_drv(5'd7, 32'hDEAD);
      push_exp(5'd7, 32'hDEAD);
      #1;
      chk("t2_ready", 64'(mdu_ready_o), 64'd1);
      cyc();
      idle();
      chk("t2_count1", 64'(buf_count_o), 64'd1);
      chk("t2_nobypass", 64'(wb_rdwe), 64'd0);
      cyc();
      chk("t2_we", 64'(wb_rdwe), 64'd1);
      chk("t2_addr", 64'(wb_rdaddr_o), 64'd7);
      chk("t2_data", 64'(wb_rddata_o), 64'hDEAD);
      chk("t2_count0", 64'(buf_count_o), 64'd0);
      cyc();
      chk("t2_idle_we", 64'(wb_rdwe), 64'd0);
      chk("t2_hold_addr", 64'(wb_rdaddr_o), 64'd7);
      chk("t2_hold_data", 64'(wb_rddata_o), 64'hDEAD);
      drain("t2_drain", 1);

      // Pop together with an rd=0 accept shrinks occupancy
      mdu_drv(5'd8, 32'h88);
      push_exp(5'd8, 32'h88);
      cyc();
      mdu_drv(5'd0, 32'h1);
      #1;
      chk("t2b_ready", 64'(mdu_ready_o), 64'd1);
      cyc();
      idle();
      chk("t2b_count", 64'(buf_count_o), 64'd0);
      drain("t2b_drain", 2);

      // Starvation: four MEM wins, then one forced MDU slot
      mdu_drv(5'd9, 32'h99);
      cyc();
      idle();
      begin
         int j;
         j = 0;
         for (int c = 0; c < 7; c++) begin
            mem_drv(5'd5, 32'h100 + 32'(j));
            #1;
            chk("t3_stall", 64'(pipe_stall_o), 64'(c == 4));
            if (c == 4) begin
               push_exp(5'd9, 32'h99);
            end else begin
               push_exp(5'd5, 32'h100 + 32'(j));
               j++;
            end
            cyc();
         end
      end
      idle();
      chk("t3_count", 64'(buf_count_o), 64'd0);
      drain("t3_drain", 2);

      // Full forces MDU; drain order follows acceptance
      mem_drv(5'd5, 32'h200);
      mdu_drv(5'd3, 32'h333);
      push_exp(5'd5, 32'h200);
      #1;
      chk("t4_stall_a", 64'(pipe_stall_o), 64'd0);
      cyc();
      mem_drv(5'd5, 32'h201);
      mdu_drv(5'd4, 32'h444);
      push_exp(5'd5, 32'h201);
      #1;
      chk("t4_ready_b", 64'(mdu_ready_o), 64'd1);
      chk("t4_stall_b", 64'(pipe_stall_o), 64'd0);
      cyc();
      mdu_valid_i = 1'b0;
      mem_drv(5'd5, 32'h202);
      #1;
      chk("t4_count_full", 64'(buf_count_o), 64'd2);
      chk("t4_ready_full", 64'(mdu_ready_o), 64'd0);
      chk("t4_stall_full", 64'(pipe_stall_o), 64'd1);
      push_exp(5'd3, 32'h333);
      cyc();
      chk("t4_count1", 64'(buf_count_o), 64'd1);
      chk("t4_stall_d", 64'(pipe_stall_o), 64'd0);
      push_exp(5'd5, 32'h202);
      cyc();
      idle();
      push_exp(5'd4, 32'h444);
      drain("t4_drain", 3);

      // x0 requests from both sides are swallowed
      mem_drv(5'd0, 32'h55);
      mdu_drv(5'd0, 32'h66);
      #1;
      chk("t5_ready", 64'(mdu_ready_o), 64'd1);
      chk("t5_stall", 64'(pipe_stall_o), 64'd0);
      cyc();
      mdu_valid_i = 1'b0;
      chk("t5_count", 64'(buf_count_o), 64'd0);
      chk("t5_we0", 64'(wb_rdwe), 64'd0);
      cyc();
      idle();
      chk("t5_we1", 64'(wb_rdwe), 64'd0);
      drain("t5_drain", 1);

      // Reset with a full queue discards it
      mem_drv(5'd6, 32'h300);
      mdu_drv(5'd10, 32'hA0);
      push_exp(5'd6, 32'h300);
      cyc();
      mem_drv(5'd6, 32'h301);
      mdu_drv(5'd11, 32'hB0);
      push_exp(5'd6, 32'h301);
      cyc();
      rst = 1'b1;
      mdu_valid_i = 1'b0;
      mem_drv(5'd6, 32'h302);
      #1;
      chk("t6_count2", 64'(buf_count_o), 64'd2);
      chk("t6_ready_rst", 64'(mdu_ready_o), 64'd0);
      chk("t6_stall_rst", 64'(pipe_stall_o), 64'd0);
      cyc();
      chk("t6_count0", 64'(buf_count_o), 64'd0);
      chk("t6_we", 64'(wb_rdwe), 64'd0);
      chk("t6_addr", 64'(wb_rdaddr_o), 64'd0);
      rst = 1'b0;
      idle();
      #1;
      chk("t6_ready_rel", 64'(mdu_ready_o), 64'd1);
      drain("t6_drain", 5);
      chk("t6_count_end", 64'(buf_count_o), 64'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
